stop_it_fsm: RTL and testbench

//   Game controller for Stop-It; drives the en_i input of game_counter and consumes its count_o.

---
 rtl/stop_it_pkg.sv | 15 +
 rtl/rise_detect.sv | 21 ++
 rtl/stop_it_fsm.sv | 131 +++++++++++++
 tb/tb_stop_it_fsm.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stop_it_pkg.sv
// Shared types and constants for the Stop-It game controller.
package stop_it_pkg;

    localparam int unsigned        COUNT_W   = 5;
    localparam logic [COUNT_W-1:0] COUNT_MAX = 5'h1f;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PLAYING = 3'd1,
        WIN     = 3'd2,
        LOSE    = 3'd3,
        OVER    = 3'd4
    } state_e;

endpackage

// File: rtl/rise_detect.sv
// Single-cycle press pulse on the rising edge of a synchronous button level.
module rise_detect (
    input  logic clk,
    input  logic rst_ni,
    input  logic level_i,
    output logic pulse_o
);

    logic r_level;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_level <= 1'b0;
        end else begin
            r_level <= level_i;
        end
    end

    assign pulse_o = level_i & ~r_level;

endmodule

// File: rtl/stop_it_fsm.sv
// Stop-It round controller: runs the down-counter, judges the stop press,
// keeps score/lives and flashes the result before returning to IDLE or OVER.
module stop_it_fsm
    import stop_it_pkg::*;
#(
    parameter  int unsigned FLASH_CYCLES = 8,
    parameter  int unsigned LIVES        = 3,
    parameter  int unsigned SCORE_W      = 4,
    localparam int unsigned LIVES_W      = $clog2(LIVES + 1)
) (
    input  logic               clk_4_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic [COUNT_W-1:0] target_i,
    input  logic [COUNT_W-1:0] count_i,
    output logic               en_o,
    output logic [COUNT_W-1:0] target_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [LIVES_W-1:0] lives_o,
    output logic [2:0]         state_o,
    output logic               flash_o,
    output logic               win_o,
    output logic               lose_o
);

    localparam int unsigned        TIMER_W   = $clog2(FLASH_CYCLES + 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    logic               w_start_pulse;
    logic               w_stop_pulse;
    state_e             r_state,  w_state_nxt;
    logic [COUNT_W-1:0] r_target, w_target_nxt;
    logic [SCORE_W-1:0] r_score,  w_score_nxt;
    logic [LIVES_W-1:0] r_lives,  w_lives_nxt;
    logic [TIMER_W-1:0] r_timer,  w_timer_nxt;
    logic               r_flash,  w_flash_nxt;

    rise_detect u_start_rise (
        .clk     (clk_4_i),
        .rst_ni  (rst_ni),
        .level_i (start_i),
        .pulse_o (w_start_pulse)
    );

    rise_detect u_stop_rise (
        .clk     (clk_4_i),
        .rst_ni  (rst_ni),
        .level_i (stop_i),
        .pulse_o (w_stop_pulse)
    );

    always_ff @(posedge clk_4_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_target <= '0;
            r_score  <= '0;
            r_lives  <= LIVES_W'(LIVES);
            r_timer  <= '0;
            r_flash  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_target <= w_target_nxt;
            r_score  <= w_score_nxt;
            r_lives  <= w_lives_nxt;
            r_timer  <= w_timer_nxt;
            r_flash  <= w_flash_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_score_nxt  = r_score;
        w_lives_nxt  = r_lives;
        w_timer_nxt  = r_timer;
        w_flash_nxt  = r_flash;

        unique case (r_state)
            IDLE: begin
                if (w_start_pulse) begin
                    w_state_nxt  = PLAYING;
                    w_target_nxt = target_i;
                end
            end
            PLAYING: begin
                // A stop press is judged before the timeout, so stopping on 0 with target 0 wins
                if (w_stop_pulse && (count_i == r_target)) begin
                    w_state_nxt = WIN;
                    w_score_nxt = (r_score == SCORE_MAX) ? r_score : r_score + SCORE_W'(1);
                    w_timer_nxt = TIMER_W'(FLASH_CYCLES - 1);
                    w_flash_nxt = 1'b1;
                end else if (w_stop_pulse || (count_i == '0)) begin
                    w_state_nxt = LOSE;
                    w_lives_nxt = (r_lives == '0) ? r_lives : r_lives - LIVES_W'(1);
                    w_timer_nxt = TIMER_W'(FLASH_CYCLES - 1);
                    w_flash_nxt = 1'b1;
                end
            end
            WIN, LOSE: begin
                if (r_timer == '0) begin
                    w_flash_nxt = 1'b0;
                    w_state_nxt = ((r_state == WIN) || (r_lives != '0)) ? IDLE : OVER;
                end else begin
                    w_timer_nxt = r_timer - TIMER_W'(1);
                    w_flash_nxt = ~r_flash;
                end
            end
            OVER: begin
                if (w_start_pulse) begin
                    w_state_nxt = IDLE;
                    w_score_nxt = '0;
                    w_lives_nxt = LIVES_W'(LIVES);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign en_o     = (r_state == PLAYING);
    assign win_o    = (r_state == WIN);
    assign lose_o   = (r_state == LOSE);
    assign state_o  = r_state;
    assign target_o = r_target;
    assign score_o  = r_score;
    assign lives_o  = r_lives;
    assign flash_o  = r_flash;

endmodule

// File: tb/tb_stop_it_fsm.sv
// Scoreboard bench for stop_it_fsm with a behavioural game_counter alongside it.
module tb_stop_it_fsm;
    import stop_it_pkg::*;

    typedef struct {
        int st;
        int cyc;
        int score;
        int lives;
        int tg;
        int en;
        int flash;
        int win;
        int lose;
        int cnt;
        bit chk_f;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [4:0] target;
    logic [4:0] cnt;
    logic [4:0] tgt_o;
    logic       en;
    logic       flash;
    logic       win;
    logic       lose;
    logic [3:0] score;
    logic [1:0] lives;
    logic [2:0] st;

    int   cyc       = 0;
    int   n_cmp     = 0;
    int   n_err     = 0;
    int   exp_score = 0;
    int   exp_lives = 3;
    exp_t sb[$];

    stop_it_fsm #(
        .FLASH_CYCLES (8),
        .LIVES        (3),
        .SCORE_W      (4)
    ) dut (
        .clk_4_i  (clk),
        .rst_ni   (rst_n),
        .start_i  (start),
        .stop_i   (stop),
        .target_i (target),
        .count_i  (cnt),
        .en_o     (en),
        .target_o (tgt_o),
        .score_o  (score),
        .lives_o  (lives),
        .state_o  (st),
        .flash_o  (flash),
        .win_o    (win),
        .lose_o   (lose)
    );

    // game_counter: parks at 31 while disabled, counts down while enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   cnt <= COUNT_MAX;
        else if (!en) cnt <= COUNT_MAX;
        else          cnt <= cnt - 5'd1;
    end

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic void chk(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, expv);
        end
    endfunction

    function automatic exp_t mk(input int s, input int c, input int tg, input int fl,
                                input int ct, input bit cf);
        exp_t e;
        e.st    = s;
        e.cyc   = c;
        e.score = exp_score;
        e.lives = exp_lives;
        e.tg    = tg;
        e.en    = (s == int'(PLAYING)) ? 1 : 0;
        e.flash = fl;
        e.win   = (s == int'(WIN)) ? 1 : 0;
        e.lose  = (s == int'(LOSE)) ? 1 : 0;
        e.cnt   = ct;
        e.chk_f = cf;
        return e;
    endfunction

    // Monitor: every state change is an output event checked against the queue head
    initial begin
        exp_t       e;
        int         prev_st;
        logic [7:0] fhist;
        prev_st = int'(IDLE);
        fhist   = '0;
        forever begin
            @(negedge clk);
            if (int'(st) != prev_st) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_transition at cycle %0d: got state %0d expected state %0d",
                             cyc, st, prev_st);
                end else begin
                    e = sb.pop_front();
                    chk("state", int'(st), e.st);
                    if (e.cyc >= 0) chk("cycle", cyc, e.cyc);
                    chk("score", int'(score), e.score);
                    chk("lives", int'(lives), e.lives);
                    chk("target", int'(tgt_o), e.tg);
                    chk("en", int'(en), e.en);
                    chk("flash", int'(flash), e.flash);
                    chk("win", int'(win), e.win);
                    chk("lose", int'(lose), e.lose);
                    if (e.cnt >= 0) chk("count", int'(cnt), e.cnt);
                    if (e.chk_f) chk("flash_seq", int'(fhist), 'hAA);
                end
                prev_st = int'(st);
            end
            if ((st == WIN) || (st == LOSE)) fhist = {fhist[6:0], flash};
            else                             fhist = '0;
        end
    end

    initial begin
        #100000;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: got time %0t expected end before it", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick();
    endtask

    task automatic start_round(input int tg, output int p);
        target = 5'(tg);
        start  = 1'b1;
        p      = cyc + 1;
        sb.push_back(mk(int'(PLAYING), p, tg, 0, 31, 1'b0));
        tick();
        start  = 1'b0;
    endtask

    // stop_at < 0 means let the counter time out; hold releases a pre-held stop first
    task automatic play(input int tg, input int stop_at, input bit exp_win, input bit hold);
        int p;
        int r;
        int ex;
        start_round(tg, p);
        if (stop_at >= 0) begin
            if (hold) begin
                wait_cyc(p + 10);
                stop = 1'b0;
            end
            wait_cyc(p + 31 - stop_at);
            stop = 1'b1;
            r    = p + 32 - stop_at;
        end else begin
            r = p + 32;
        end
        if (exp_win) exp_score = (exp_score == 15) ? 15 : exp_score + 1;
        else         exp_lives = (exp_lives == 0) ? 0 : exp_lives - 1;
        sb.push_back(mk(exp_win ? int'(WIN) : int'(LOSE), r, tg, 1, -1, 1'b0));
        ex = (exp_win || (exp_lives != 0)) ? int'(IDLE) : int'(OVER);
        sb.push_back(mk(ex, r + 8, tg, 0, 31, 1'b1));
        if (stop_at >= 0) begin
            tick();
            stop = 1'b0;
        end
        wait_cyc(r + 8);
        tick();
    endtask

    task automatic pulse_reset_idle();
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        exp_score = 0;
        exp_lives = 3;
        tick();
    endtask

    initial begin
        int p;
        rst_n  = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        target = '0;
        #22 rst_n = 1'b1;
        tick();

        chk("rst_state", int'(st), int'(IDLE));
        chk("rst_en", int'(en), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_lives", int'(lives), 3);
        chk("rst_target", int'(tgt_o), 0);
        chk("rst_flash", int'(flash), 0);
        chk("rst_count", int'(cnt), 31);

        play(10, 10, 1'b1, 1'b0);
        play(10, 11, 1'b0, 1'b0);
        play(7, -1, 1'b0, 1'b0);
        play(0, 0, 1'b1, 1'b0);

        pulse_reset_idle();
        play(3, 4, 1'b0, 1'b0);
        play(3, -1, 1'b0, 1'b0);
        play(20, 30, 1'b0, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        tick();
        exp_score = 0;
        exp_lives = 3;
        start = 1'b1;
        sb.push_back(mk(int'(IDLE), cyc + 1, 20, 0, 31, 1'b0));
        tick();
        start = 1'b0;
        tick();

        stop = 1'b1;
        tick();
        play(5, 5, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) play(10, 10, 1'b1, 1'b0);
        chk("score_sat", int'(score), 15);

        start_round(12, p);
        wait_cyc(p + 5);
        exp_score = 0;
        exp_lives = 3;
        sb.push_back(mk(int'(IDLE), -1, 0, 0, 31, 1'b0));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_state", int'(st), int'(IDLE));
        chk("async_rst_en", int'(en), 0);
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_count", int'(cnt), 31);
        chk("post_rst_state", int'(st), int'(IDLE));
        tick();
        tick();

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
